// File: rtl/mesh_prog_pkg.sv
// Shared types and constants for the Accelerant mesh programmer.
// Holds the programmer FSM state encoding and the PE instruction codes.
package mesh_prog_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

   localparam logic [3:0] INSTR_FADD      = 4'b0000;
   localparam logic [3:0] INSTR_FMUL      = 4'b0001;
   localparam logic [3:0] INSTR_LOAD_DATA = 4'b0010;
   localparam logic [3:0] INSTR_FMA       = 4'b0011;
   localparam logic [3:0] INSTR_SYS_FMA   = 4'b1010;

   localparam int unsigned DATA_W_DEFAULT = 32;

endpackage

// File: rtl/mesh_result_drain.sv
// Result drain for the mesh programmer: walks PE indices and presents each word on a
// valid/ready stream. Defining MESH_PROG_SNAPSHOT_EN freezes all PE words at drain start.
module mesh_result_drain
   import mesh_prog_pkg::*;
#(
   parameter int unsigned NUM_PE = 16,
   parameter int unsigned IDX_W  = $clog2(NUM_PE),
   parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     start,
   input  logic [NUM_PE*DATA_W-1:0] pe_result_in,
   input  logic                     res_ready,
   output logic                     res_valid,
   output logic [IDX_W-1:0]         res_pe_idx,
   output logic [DATA_W-1:0]        res_data,
   output logic                     last_accept
);

   logic [IDX_W-1:0]         idx_q;
   logic [IDX_W-1:0]         idx_next;
   logic                     valid_q;
   logic [DATA_W-1:0]        data_q;
   logic [DATA_W-1:0]        next_word;
   logic [NUM_PE*DATA_W-1:0] src_words;
   logic                     accept;
   logic                     at_last;

   assign accept      = valid_q && res_ready;
   assign at_last     = (idx_q == IDX_W'(NUM_PE - 1));
   assign idx_next    = idx_q + 1'b1;
   assign last_accept = accept && at_last;

`ifdef MESH_PROG_SNAPSHOT_EN
   logic [NUM_PE*DATA_W-1:0] snap_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         snap_q <= '0;
      end else if (start) begin
         snap_q <= pe_result_in;
      end
   end

   assign src_words = snap_q;
`else
   // Live PE outputs; a stalled word keeps the value sampled when idx last advanced.
   assign src_words = pe_result_in;
`endif

   always_comb begin
      next_word = '0;
      for (int i = 0; i < int'(NUM_PE); i++) begin
         if (int'(idx_next) == i) begin
            next_word = src_words[i*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         idx_q   <= '0;
         valid_q <= 1'b0;
         data_q  <= '0;
      end else if (start) begin
         idx_q   <= '0;
         valid_q <= 1'b1;
         data_q  <= pe_result_in[DATA_W-1:0];
      end else if (accept) begin
         if (at_last) begin
            valid_q <= 1'b0;
         end else begin
            idx_q  <= idx_next;
            data_q <= next_word;
         end
      end
   end

   assign res_valid  = valid_q;
   assign res_pe_idx = idx_q;
   assign res_data   = data_q;

endmodule

// File: rtl/mesh_programmer.sv
// Switch-side master for a PE row/column: programs PEs, runs them, then drains results.
// Optional MESH_PROG_SNAPSHOT_EN (see mesh_result_drain) snapshots results at drain start.
module mesh_programmer
   import mesh_prog_pkg::*;
#(
   parameter int unsigned NUM_PE = 16,
   parameter int unsigned IDX_W  = $clog2(NUM_PE),
   parameter int unsigned DATA_W = DATA_W_DEFAULT,
   parameter int unsigned CYC_W  = 16
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic                     cmd_broadcast,
   input  logic [IDX_W-1:0]         cmd_pe_idx,
   input  logic [3:0]               cmd_instruction,
   input  logic [DATA_W-1:0]        cmd_data,
   input  logic                     run_start,
   input  logic [3:0]               run_instruction,
   input  logic [CYC_W-1:0]         run_cycles,
   output logic [NUM_PE-1:0]        pe_load,
   output logic [3:0]               pe_instruction,
   output logic [DATA_W-1:0]        pe_data,
   input  logic [NUM_PE*DATA_W-1:0] pe_result_in,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [IDX_W-1:0]         res_pe_idx,
   output logic [DATA_W-1:0]        res_data,
   output logic                     busy,
   output logic                     done
);

   state_e            state_q, state_d;
   logic [CYC_W-1:0]  cnt_q, cnt_d;
   logic [CYC_W-1:0]  cycles_q, cycles_d;
   logic [NUM_PE-1:0] load_q, load_d;
   logic [3:0]        instr_q, instr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              busy_q, done_q;
   logic              cmd_fire;
   logic              drain_start;
   logic              last_accept;

   // run_start wins over a simultaneous command.
   assign cmd_ready = (state_q == IDLE) && !run_start;
   assign cmd_fire  = cmd_valid && cmd_ready;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cycles_d    = cycles_q;
      load_d      = '0;
      instr_d     = instr_q;
      data_d      = data_q;
      drain_start = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (run_start) begin
               cycles_d = run_cycles;
               cnt_d    = '0;
               instr_d  = run_instruction;
               if (run_cycles == '0) begin
                  state_d     = DRAIN;
                  drain_start = 1'b1;
               end else begin
                  state_d = RUN;
               end
            end else if (cmd_fire) begin
               // Out-of-range indices match no bit, so the load is dropped.
               for (int i = 0; i < int'(NUM_PE); i++) begin
                  load_d[i] = cmd_broadcast || (int'(cmd_pe_idx) == i);
               end
               instr_d = cmd_instruction;
               data_d  = cmd_data;
            end
         end
         RUN: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == cycles_q - CYC_W'(1)) begin
               state_d     = DRAIN;
               drain_start = 1'b1;
            end
         end
         DRAIN: begin
            if (last_accept) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         cycles_q <= '0;
         load_q   <= '0;
         instr_q  <= INSTR_FADD;
         data_q   <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         cycles_q <= cycles_d;
         load_q   <= load_d;
         instr_q  <= instr_d;
         data_q   <= data_d;
         busy_q   <= (state_d != IDLE);
         done_q   <= (state_d == DONE);
      end
   end

   mesh_result_drain #(
      .NUM_PE (NUM_PE),
      .IDX_W  (IDX_W),
      .DATA_W (DATA_W)
   ) u_drain (
      .clk          (clk),
      .reset_n      (reset_n),
      .start        (drain_start),
      .pe_result_in (pe_result_in),
      .res_ready    (res_ready),
      .res_valid    (res_valid),
      .res_pe_idx   (res_pe_idx),
      .res_data     (res_data),
      .last_accept  (last_accept)
   );

   assign pe_load        = load_q;
   assign pe_instruction = instr_q;
   assign pe_data        = data_q;
   assign busy           = busy_q;
   assign done           = done_q;

endmodule
